shot_resolver: RTL and testbench

- Downstream consumer of Ppos_ships: takes the finished placement board and resolves attack shots fired at player-selected (x,y) cells.
- Latches the board on load, then marks each confirmed shot as miss, hit or sunk, and tracks remaining ship cells down to game over.
- Feeds the display/turn controller with the updated board and a one-cycle result strobe.

---
 rtl/battleship_pkg.sv | 27 ++
 rtl/ship_cell_scan.sv | 37 +++
 rtl/shot_resolver.sv | 221 ++++++++++++++++++++++
 tb/tb_shot_resolver.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// Shared battleship definitions: cell codes, shot result encoding and the
// board type. Used by the placement stage and by shot_resolver.
package battleship_pkg;

    localparam int BOARD_N = 5;
    localparam int CELL_W  = 3;

    localparam logic [CELL_W-1:0] CELL_WATER  = 3'd0;
    localparam logic [CELL_W-1:0] SHIP_ID_MAX = 3'd5;
    localparam logic [CELL_W-1:0] CELL_MISS   = 3'd6;
    localparam logic [CELL_W-1:0] CELL_HIT    = 3'd7;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_MISS = 2'd1,
        RES_HIT  = 2'd2,
        RES_SUNK = 2'd3
    } result_e;

    typedef logic [BOARD_N-1:0][BOARD_N-1:0][CELL_W-1:0] board_t;

    // True for an intact ship cell (ids 1..5)
    function automatic logic is_ship(input logic [CELL_W-1:0] code);
        return (code != CELL_WATER) && (code <= SHIP_ID_MAX);
    endfunction

endpackage

// File: rtl/ship_cell_scan.sv
// Combinational board scan: flags whether any cell still holds ship `id`
// and counts all intact ship cells on the board.
module ship_cell_scan
    import battleship_pkg::*;
#(
    parameter int N     = BOARD_N,
    parameter int CW    = CELL_W,
    parameter int CNT_W = 5
) (
    input  logic [N-1:0][N-1:0][CW-1:0] board,
    input  logic [CW-1:0]               id,
    output logic                        any_left,
    output logic [CNT_W-1:0]            count
);

    logic [N*N-1:0] match_bits;
    logic [N*N-1:0] ship_bits;

    // Per-cell classification, flattened row-major
    genvar gi;
    generate
        for (gi = 0; gi < N*N; gi++) begin : g_cell
            assign match_bits[gi] = (board[gi / N][gi % N] == id);
            assign ship_bits[gi]  = is_ship(board[gi / N][gi % N]);
        end
    endgenerate

    // Reduce the per-cell flags into the two results
    always_comb begin
        any_left = |match_bits;
        count    = '0;
        for (int i = 0; i < N*N; i++) begin
            count = count + CNT_W'(ship_bits[i]);
        end
    end

endmodule

// File: rtl/shot_resolver.sv
// Shot resolver: latches a placement board on load, then resolves each
// fired shot as miss / hit / sunk, tracking remaining ship cells until
// game over. Optional shot/hit statistics are enabled by SHOT_STATS_EN.
module shot_resolver
    import battleship_pkg::*;
#(
    parameter int N  = 5,
    parameter int CW = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic                        enable,
    input  logic                        confirm,
    input  logic [2:0]                  x,
    input  logic [2:0]                  y,
    input  logic [N-1:0][N-1:0][CW-1:0] board_in,
    output logic [N-1:0][N-1:0][CW-1:0] board_out,
    output logic [1:0]                  result,
    output logic                        result_valid,
    output logic                        invalid,
    output logic [4:0]                  remaining,
    output logic                        game_over
`ifdef SHOT_STATS_EN
    ,
    output logic [5:0]                  shots,
    output logic [5:0]                  hits
`endif
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_READY  = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_UPDATE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [2:0] N_L     = 3'(N);
    localparam logic [5:0] STAT_MAX = 6'd63;

    logic [2:0]                  state_q, state_d;
    logic [N-1:0][N-1:0][CW-1:0] board_q, board_d;
    result_e                     result_q, result_d;
    logic                        result_valid_q, result_valid_d;
    logic                        invalid_q, invalid_d;
    logic [4:0]                  remaining_q, remaining_d;
    logic                        game_over_q, game_over_d;
    logic                        confirm_q, confirm_d;
    logic [2:0]                  shot_x_q, shot_x_d;
    logic [2:0]                  shot_y_q, shot_y_d;
    logic [CW-1:0]               shot_c_q, shot_c_d;
`ifdef SHOT_STATS_EN
    logic [5:0]                  shots_q, shots_d;
    logic [5:0]                  hits_q, hits_d;
`endif

    logic                        fire;
    logic [CW-1:0]               cell_at_xy;
    logic [N-1:0][N-1:0][CW-1:0] scan_board;
    logic                        scan_any_left;
    logic [4:0]                  scan_count;

    // One scanner serves both jobs: load count (board_in) and sunk check
    // (post-write internal board, only consulted in UPDATE)
    assign scan_board = (state_q == ST_UPDATE) ? board_q : board_in;

    ship_cell_scan #(.N(N), .CW(CW), .CNT_W(5)) u_scan (
        .board    (scan_board),
        .id       (shot_c_q),
        .any_left (scan_any_left),
        .count    (scan_count)
    );

    assign fire = enable & confirm & ~confirm_q;

    // Cell under the requested shot; out-of-range coordinates read as water
    // and are rejected in CHECK anyway
    always_comb begin
        cell_at_xy = CELL_WATER;
        for (int yi = 0; yi < N; yi++) begin
            for (int xi = 0; xi < N; xi++) begin
                if (y == 3'(yi) && x == 3'(xi)) begin
                    cell_at_xy = board_q[yi][xi];
                end
            end
        end
    end

    // Next-state logic for the shot FSM, board, counters and strobes
    always_comb begin
        state_d        = state_q;
        board_d        = board_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        invalid_d      = 1'b0;
        remaining_d    = remaining_q;
        game_over_d    = game_over_q;
        confirm_d      = confirm;
        shot_x_d       = shot_x_q;
        shot_y_d       = shot_y_q;
        shot_c_d       = shot_c_q;
`ifdef SHOT_STATS_EN
        shots_d        = shots_q;
        hits_d         = hits_q;
`endif

        case (state_q)
            ST_IDLE, ST_READY, ST_DONE: begin
                if (load) begin
                    // Load has priority over a simultaneous fire
                    board_d     = board_in;
                    remaining_d = scan_count;
                    game_over_d = (scan_count == 5'd0);
                    state_d     = (scan_count == 5'd0) ? ST_DONE : ST_READY;
`ifdef SHOT_STATS_EN
                    shots_d     = 6'd0;
                    hits_d      = 6'd0;
`endif
                end else if (state_q == ST_READY && fire) begin
                    shot_x_d = x;
                    shot_y_d = y;
                    shot_c_d = cell_at_xy;
                    state_d  = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (shot_x_q >= N_L || shot_y_q >= N_L ||
                    shot_c_q == CELL_MISS || shot_c_q == CELL_HIT) begin
                    invalid_d = 1'b1;
                    state_d   = ST_READY;
                end else begin
                    for (int yi = 0; yi < N; yi++) begin
                        for (int xi = 0; xi < N; xi++) begin
                            if (shot_y_q == 3'(yi) && shot_x_q == 3'(xi)) begin
                                board_d[yi][xi] = (shot_c_q == CELL_WATER) ? CELL_MISS : CELL_HIT;
                            end
                        end
                    end
                    if (shot_c_q == CELL_WATER) begin
                        result_d = RES_MISS;
                    end else if (remaining_q != 5'd0) begin
                        remaining_d = remaining_q - 5'd1;
                    end
                    state_d = ST_UPDATE;
                end
            end

            ST_UPDATE: begin
                result_valid_d = 1'b1;
                if (shot_c_q != CELL_WATER) begin
                    result_d = scan_any_left ? RES_HIT : RES_SUNK;
                end
`ifdef SHOT_STATS_EN
                if (shots_q != STAT_MAX) begin
                    shots_d = shots_q + 6'd1;
                end
                if (shot_c_q != CELL_WATER && hits_q != STAT_MAX) begin
                    hits_d = hits_q + 6'd1;
                end
`endif
                if (remaining_q == 5'd0) begin
                    game_over_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_READY;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            board_q        <= '0;
            result_q       <= RES_NONE;
            result_valid_q <= 1'b0;
            invalid_q      <= 1'b0;
            remaining_q    <= 5'd0;
            game_over_q    <= 1'b0;
            confirm_q      <= 1'b0;
            shot_x_q       <= 3'd0;
            shot_y_q       <= 3'd0;
            shot_c_q       <= CELL_WATER;
`ifdef SHOT_STATS_EN
            shots_q        <= 6'd0;
            hits_q         <= 6'd0;
`endif
        end else begin
            state_q        <= state_d;
            board_q        <= board_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            invalid_q      <= invalid_d;
            remaining_q    <= remaining_d;
            game_over_q    <= game_over_d;
            confirm_q      <= confirm_d;
            shot_x_q       <= shot_x_d;
            shot_y_q       <= shot_y_d;
            shot_c_q       <= shot_c_d;
`ifdef SHOT_STATS_EN
            shots_q        <= shots_d;
            hits_q         <= hits_d;
`endif
        end
    end

    assign board_out    = board_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign invalid      = invalid_q;
    assign remaining    = remaining_q;
    assign game_over    = game_over_q;
`ifdef SHOT_STATS_EN
    assign shots        = shots_q;
    assign hits         = hits_q;
`endif

endmodule

// File: tb/tb_shot_resolver.sv
// Directed testbench for shot_resolver (5x5 board, 3-bit cells).
module tb_shot_resolver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n, load, enable, confirm;
    logic [2:0]               x, y;
    logic [4:0][4:0][2:0]     board_in, board_out, exp_board, b1;
    logic [1:0]               result;
    logic                     result_valid, invalid, game_over;
    logic [4:0]               remaining;
`ifdef SHOT_STATS_EN
    logic [5:0]               shots, hits;
`endif

    int checks   = 0;
    int failures = 0;
    int last_lat;
    int last_inv;
    int last_pulses;

    shot_resolver #(.N(5), .CW(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .enable       (enable),
        .confirm      (confirm),
        .x            (x),
        .y            (y),
        .board_in     (board_in),
        .board_out    (board_out),
        .result       (result),
        .result_valid (result_valid),
        .invalid      (invalid),
        .remaining    (remaining),
        .game_over    (game_over)
`ifdef SHOT_STATS_EN
        ,
        .shots        (shots),
        .hits         (hits)
`endif
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Fire one shot (rising confirm) and watch 4 cycles for its response.
    // Called and returns at 1 time unit after a rising edge.
    task automatic do_shot(input logic [2:0] sx, input logic [2:0] sy);
        x = sx; y = sy; enable = 1'b1; confirm = 1'b1;
        @(posedge clk); #1;
        confirm = 1'b0;
        last_lat = 0; last_inv = 0; last_pulses = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (result_valid || invalid) begin
                last_pulses++;
                if (last_lat == 0) begin
                    last_lat = k;
                    last_inv = int'(invalid);
                end
            end
        end
        $display("shot x=%0d y=%0d lat=%0d inv=%0d result=%0d remaining=%0d game_over=%0d",
                 sx, sy, last_lat, last_inv, result, remaining, game_over);
    endtask

    task automatic do_load(input logic [4:0][4:0][2:0] b);
        board_in = b; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        $display("load remaining=%0d game_over=%0d", remaining, game_over);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_board"},     board_out,    '0);
        check_val({tag, "_result"},    result,       0);
        check_val({tag, "_rvalid"},    result_valid, 0);
        check_val({tag, "_invalid"},   invalid,      0);
        check_val({tag, "_remaining"}, remaining,    0);
        check_val({tag, "_gameover"},  game_over,    0);
`ifdef SHOT_STATS_EN
        check_val({tag, "_shots"},     shots,        0);
        check_val({tag, "_hits"},      hits,         0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; enable = 1'b0; confirm = 1'b0;
        x = 3'd0; y = 3'd0; board_in = '0;
        b1 = '0;
        b1[0][0] = 3'd3; b1[0][1] = 3'd3; b1[0][2] = 3'd3;

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;

        // Empty board: no ships, straight to game over; shots ignored
        do_load('0);
        check_val("empty_gameover", game_over, 1);
        check_val("empty_remaining", remaining, 0);
        do_shot(3'd0, 3'd0);
        check_val("empty_no_resp", last_pulses, 0);

        // Real board: ship 3 along row 0
        do_load(b1);
        exp_board = b1;
        check_val("load_remaining", remaining, 3);
        check_val("load_gameover", game_over, 0);
        check_val("load_board", board_out, exp_board);

        // Miss at (4,4)
        do_shot(3'd4, 3'd4);
        exp_board[4][4] = 3'd6;
        check_val("miss_lat", last_lat, 2);
        check_val("miss_inv", last_inv, 0);
        check_val("miss_result", result, 1);
        check_val("miss_board", board_out, exp_board);
        check_val("miss_remaining", remaining, 3);

        // Hit at (0,0)
        do_shot(3'd0, 3'd0);
        exp_board[0][0] = 3'd7;
        check_val("hit1_lat", last_lat, 2);
        check_val("hit1_result", result, 2);
        check_val("hit1_remaining", remaining, 2);
        check_val("hit1_board", board_out, exp_board);

        // Repeat (0,0): invalid, nothing changes
        do_shot(3'd0, 3'd0);
        check_val("repeat_lat", last_lat, 1);
        check_val("repeat_inv", last_inv, 1);
        check_val("repeat_remaining", remaining, 2);
        check_val("repeat_board", board_out, exp_board);
        check_val("repeat_result_held", result, 2);

        // Out of range x=5
        do_shot(3'd5, 3'd0);
        check_val("oor_lat", last_lat, 1);
        check_val("oor_inv", last_inv, 1);
        check_val("oor_board", board_out, exp_board);

        // Hold confirm 4 cycles at (1,1): exactly one shot
        x = 3'd1; y = 3'd1; enable = 1'b1; confirm = 1'b1;
        last_pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 4) confirm = 1'b0;
            last_pulses += int'(result_valid);
        end
        exp_board[1][1] = 3'd6;
        $display("hold confirm x=1 y=1 pulses=%0d result=%0d", last_pulses, result);
        check_val("hold_pulses", last_pulses, 1);
        check_val("hold_result", result, 1);
        check_val("hold_board", board_out, exp_board);

        // enable low: confirm pulse ignored
        enable = 1'b0; confirm = 1'b1; x = 3'd3; y = 3'd3;
        last_pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 1) confirm = 1'b0;
            last_pulses += int'(result_valid | invalid);
        end
        $display("disabled confirm x=3 y=3 pulses=%0d", last_pulses);
        check_val("disabled_pulses", last_pulses, 0);
        check_val("disabled_board", board_out, exp_board);

        // Hit (1,0), then sink with (2,0)
        do_shot(3'd1, 3'd0);
        exp_board[0][1] = 3'd7;
        check_val("hit2_result", result, 2);
        check_val("hit2_remaining", remaining, 1);
        check_val("hit2_gameover", game_over, 0);

        do_shot(3'd2, 3'd0);
        exp_board[0][2] = 3'd7;
        check_val("sunk_lat", last_lat, 2);
        check_val("sunk_result", result, 3);
        check_val("sunk_remaining", remaining, 0);
        check_val("sunk_gameover", game_over, 1);
        check_val("sunk_board", board_out, exp_board);
`ifdef SHOT_STATS_EN
        check_val("stats_shots", shots, 5);
        check_val("stats_hits", hits, 3);
`endif

        // After game over, further shots are ignored
        do_shot(3'd3, 3'd3);
        check_val("over_no_resp", last_pulses, 0);
        check_val("over_gameover_held", game_over, 1);
        check_val("over_board", board_out, exp_board);

        // Reload from DONE
        do_load(b1);
        check_val("reload_remaining", remaining, 3);
        check_val("reload_gameover", game_over, 0);
        check_val("reload_board", board_out, b1);
`ifdef SHOT_STATS_EN
        check_val("reload_shots", shots, 0);
        check_val("reload_hits", hits, 0);
`endif

        // Reset during CHECK aborts the shot
        x = 3'd0; y = 3'd0; enable = 1'b1; confirm = 1'b1;
        @(posedge clk); #1;
        confirm = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        $display("reset in CHECK remaining=%0d result=%0d", remaining, result);
        check_reset_state("midreset");
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
